// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit
//   Tracks predicted branches in flight between fetch and execute. Fetch pushes
//   {table index, predicted direction}; execute resolves the oldest entry. Each
//   resolve produces a one-cycle table update; a direction mismatch produces a
//   one-cycle flush with the corrected fetch PC and discards every younger entry.
//
// Ports
//   clk, arst_n           rising-edge clock, asynchronous active-low reset
//   pred_valid/ready      push handshake from fetch
//   pred_idx, pred_taken  table index and predicted direction of the pushed branch
//   res_valid             execute resolves the oldest in-flight branch
//   res_taken             actual direction
//   res_target/fallthru   taken-path / not-taken-path PCs
//   upd_en/addr/taken     table write strobe, index and outcome (1 cycle after resolve)
//   flush, redirect_pc    wrong-path squash and corrected PC (1 cycle after mispredict)
//   err_underflow         sticky: a resolve arrived with nothing in flight
//
// Optional build macro
//   BRU_STATS_EN  adds saturating 16-bit outputs stat_branches and stat_mispred.

module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int IDX_W = 5
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             pred_valid,
    output logic             pred_ready,
    input  logic [IDX_W-1:0] pred_idx,
    input  logic             pred_taken,
    input  logic             res_valid,
    input  logic             res_taken,
    input  logic [31:0]      res_target,
    input  logic [31:0]      res_fallthru,
    output logic             upd_en,
    output logic [IDX_W-1:0] upd_addr,
    output logic             upd_taken,
    output logic             flush,
    output logic [31:0]      redirect_pc,
    output logic             err_underflow
`ifdef BRU_STATS_EN
    ,
    output logic [15:0]      stat_branches,
    output logic [15:0]      stat_mispred
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {RUN, FLUSH, REFILL} state_e;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               upd_en_q, upd_en_d;
    logic [IDX_W-1:0]   upd_addr_q, upd_addr_d;
    logic               upd_taken_q, upd_taken_d;
    logic               flush_q, flush_d;
    logic [31:0]        redirect_q, redirect_d;
    logic               err_q, err_d;

    // Entry layout: {idx, predicted taken}
    logic [IDX_W:0]     fifo_mem [DEPTH];
    logic [IDX_W:0]     head_entry;
    logic [IDX_W-1:0]   head_idx;
    logic               head_taken;

    logic in_run, not_empty, full, pop, mispred, underflow, push;

    assign head_entry = fifo_mem[rd_ptr_q];
    assign head_idx   = head_entry[IDX_W:1];
    assign head_taken = head_entry[0];

    assign in_run    = (state_q == RUN);
    assign not_empty = (count_q != '0);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign pop       = in_run & res_valid & not_empty;
    assign mispred   = pop & (head_taken != res_taken);
    assign underflow = in_run & res_valid & ~not_empty;

    // A same-cycle pop frees a slot, so a full queue still accepts the push.
    assign pred_ready = in_run & (~full | pop);
    // Anything pushed alongside a mispredict is on the wrong path.
    assign push       = pred_valid & pred_ready & ~mispred;

    // Entry storage carries no reset; count/pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {pred_idx, pred_taken};
        end
    end

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        upd_en_d    = pop;
        upd_addr_d  = upd_addr_q;
        upd_taken_d = upd_taken_q;
        flush_d     = mispred;
        redirect_d  = redirect_q;
        err_d       = err_q | underflow;

        if (pop) begin
            upd_addr_d  = head_idx;
            upd_taken_d = res_taken;
        end
        if (mispred) begin
            redirect_d = res_taken ? res_target : res_fallthru;
        end

        case (state_q)
            RUN: begin
                if (mispred) begin
                    state_d  = FLUSH;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    count_d  = '0;
                end else begin
                    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    count_d = count_q + CNT_W'(push) - CNT_W'(pop);
                end
            end
            FLUSH:   state_d = REFILL;
            REFILL:  state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state_q     <= RUN;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            upd_en_q    <= 1'b0;
            upd_addr_q  <= '0;
            upd_taken_q <= 1'b0;
            flush_q     <= 1'b0;
            redirect_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            upd_en_q    <= upd_en_d;
            upd_addr_q  <= upd_addr_d;
            upd_taken_q <= upd_taken_d;
            flush_q     <= flush_d;
            redirect_q  <= redirect_d;
            err_q       <= err_d;
        end
    end

    assign upd_en        = upd_en_q;
    assign upd_addr      = upd_addr_q;
    assign upd_taken     = upd_taken_q;
    assign flush         = flush_q;
    assign redirect_pc   = redirect_q;
    assign err_underflow = err_q;

`ifdef BRU_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] stat_branches_q, stat_mispred_q;

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            if (pop)     stat_branches_q <= sat_inc(stat_branches_q);
            if (mispred) stat_mispred_q  <= sat_inc(stat_mispred_q);
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;
    localparam int IDX_W = 5;

    logic             clk = 1'b0;
    logic             arst_n;
    logic             pred_valid;
    logic             pred_ready;
    logic [IDX_W-1:0] pred_idx;
    logic             pred_taken;
    logic             res_valid;
    logic             res_taken;
    logic [31:0]      res_target;
    logic [31:0]      res_fallthru;
    logic             upd_en;
    logic [IDX_W-1:0] upd_addr;
    logic             upd_taken;
    logic             flush;
    logic [31:0]      redirect_pc;
    logic             err_underflow;
`ifdef BRU_STATS_EN
    logic [15:0]      stat_branches;
    logic [15:0]      stat_mispred;
`endif

    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk          (clk),
        .arst_n       (arst_n),
        .pred_valid   (pred_valid),
        .pred_ready   (pred_ready),
        .pred_idx     (pred_idx),
        .pred_taken   (pred_taken),
        .res_valid    (res_valid),
        .res_taken    (res_taken),
        .res_target   (res_target),
        .res_fallthru (res_fallthru),
        .upd_en       (upd_en),
        .upd_addr     (upd_addr),
        .upd_taken    (upd_taken),
        .flush        (flush),
        .redirect_pc  (redirect_pc),
        .err_underflow(err_underflow)
`ifdef BRU_STATS_EN
        ,
        .stat_branches(stat_branches),
        .stat_mispred (stat_mispred)
`endif
    );

    // Reference model: in-flight branches as a queue, plus a count of
    // cycles during which the unit is recovering from a mispredict.
    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic             tkn;
    } ent_t;

    ent_t             mq[$];
    int               busy = 0;
    logic             m_err = 1'b0;
    logic             e_upd_en = 1'b0;
    logic [IDX_W-1:0] e_upd_addr = '0;
    logic             e_upd_taken = 1'b0;
    logic             e_flush = 1'b0;
    logic [31:0]      e_redir = '0;

    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_ready();
        return (busy == 0) && ((mq.size() < DEPTH) || (res_valid && mq.size() > 0));
    endfunction

    task automatic model_step();
        bit   rdy;
        bit   mis;
        ent_t h;
        ent_t n;
        if (!arst_n) begin
            mq.delete();
            busy        = 0;
            m_err       = 1'b0;
            e_upd_en    = 1'b0;
            e_upd_addr  = '0;
            e_upd_taken = 1'b0;
            e_flush     = 1'b0;
            e_redir     = '0;
        end else begin
            rdy      = exp_ready();
            mis      = 1'b0;
            e_upd_en = 1'b0;
            e_flush  = 1'b0;
            if (busy > 0) begin
                busy--;
            end else begin
                if (res_valid) begin
                    if (mq.size() == 0) begin
                        m_err = 1'b1;
                    end else begin
                        h           = mq.pop_front();
                        e_upd_en    = 1'b1;
                        e_upd_addr  = h.idx;
                        e_upd_taken = res_taken;
                        if (h.tkn != res_taken) begin
                            mis     = 1'b1;
                            e_flush = 1'b1;
                            e_redir = res_taken ? res_target : res_fallthru;
                            mq.delete();
                            busy    = 2;
                        end
                    end
                end
                if (pred_valid && rdy && !mis) begin
                    n.idx = pred_idx;
                    n.tkn = pred_taken;
                    mq.push_back(n);
                end
            end
        end
    endtask

    initial forever begin
        @(posedge clk or negedge arst_n);
        model_step();
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (arst_n && cmp_on) begin
            chk("pred_ready", 32'(pred_ready), 32'(exp_ready()));
            chk("upd_en", 32'(upd_en), 32'(e_upd_en));
            chk("flush", 32'(flush), 32'(e_flush));
            chk("err_underflow", 32'(err_underflow), 32'(m_err));
            chk("count", 32'(dut.count_q), 32'(mq.size()));
            if (e_upd_en) begin
                chk("upd_addr", 32'(upd_addr), 32'(e_upd_addr));
                chk("upd_taken", 32'(upd_taken), 32'(e_upd_taken));
            end
            if (e_flush) chk("redirect_pc", redirect_pc, e_redir);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        pred_valid = 1'b0;
        res_valid  = 1'b0;
    endtask

    task automatic pulse_reset();
        arst_n = 1'b0;
        #1;
        arst_n = 1'b1;
    endtask

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL timeout: simulation exceeded its time budget");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int exp_a[4];
        int exp_t[4];
        arst_n       = 1'b0;
        pred_valid   = 1'b0;
        pred_idx     = '0;
        pred_taken   = 1'b0;
        res_valid    = 1'b0;
        res_taken    = 1'b0;
        res_target   = '0;
        res_fallthru = '0;
        #12;
        chk("rst_upd_en", 32'(upd_en), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_redirect", redirect_pc, 32'd0);
        chk("rst_err", 32'(err_underflow), 32'd0);
        chk("rst_ready", 32'(pred_ready), 32'd1);
        step();
        arst_n = 1'b1;
        cmp_on = 1'b1;

        // Correct prediction
        pred_valid = 1'b1; pred_idx = 5'd3; pred_taken = 1'b1;
        step();
        pred_valid = 1'b0; res_valid = 1'b1; res_taken = 1'b1;
        step();
        idle();
        chk("s1_upd_en", 32'(upd_en), 32'd1);
        chk("s1_upd_addr", 32'(upd_addr), 32'd3);
        chk("s1_upd_taken", 32'(upd_taken), 32'd1);
        chk("s1_flush", 32'(flush), 32'd0);

        // Mispredict: not-taken predicted, taken resolved
        pred_valid = 1'b1; pred_idx = 5'd7; pred_taken = 1'b0;
        step();
        pred_valid = 1'b0; res_valid = 1'b1; res_taken = 1'b1;
        res_target = 32'h40; res_fallthru = 32'h1234;
        step();
        idle();
        chk("s2_flush", 32'(flush), 32'd1);
        chk("s2_redirect", redirect_pc, 32'h40);
        chk("s2_ready_c1", 32'(pred_ready), 32'd0);
        step();
        chk("s2_flush_c2", 32'(flush), 32'd0);
        chk("s2_ready_c2", 32'(pred_ready), 32'd0);
        step();
        chk("s2_ready_c3", 32'(pred_ready), 32'd1);
        chk("s2_count", 32'(dut.count_q), 32'd0);

        // Fill, then push + pop on a full queue, then drain across the wrap
        for (int i = 0; i < 4; i++) begin
            pred_valid = 1'b1; pred_idx = 5'(10 + i); pred_taken = i[0];
            step();
        end
        pred_valid = 1'b0;
        #1;
        chk("s3_full_ready", 32'(pred_ready), 32'd0);
        pred_valid = 1'b1; pred_idx = 5'd20; pred_taken = 1'b1;
        res_valid = 1'b1; res_taken = 1'b0;
        #1;
        chk("s3_ready_with_pop", 32'(pred_ready), 32'd1);
        step();
        idle();
        chk("s3_upd_addr", 32'(upd_addr), 32'd10);
        chk("s3_count", 32'(dut.count_q), 32'd4);
        exp_a = '{11, 12, 13, 20};
        exp_t = '{1, 0, 1, 1};
        for (int k = 0; k < 4; k++) begin
            res_valid = 1'b1; res_taken = exp_t[k][0];
            step();
            res_valid = 1'b0;
            chk("s3_drain_en", 32'(upd_en), 32'd1);
            chk("s3_drain_addr", 32'(upd_addr), 32'(exp_a[k]));
            chk("s3_drain_flush", 32'(flush), 32'd0);
        end

        // Resolve on empty queue
        pulse_reset();
        res_valid = 1'b1; res_taken = 1'b1;
        step();
        res_valid = 1'b0;
        chk("s4_upd_en", 32'(upd_en), 32'd0);
        chk("s4_err", 32'(err_underflow), 32'd1);
        step();
        step();
        chk("s4_err_sticky", 32'(err_underflow), 32'd1);

        // Reset during the flush cycle
        pulse_reset();
        pred_valid = 1'b1; pred_idx = 5'd5; pred_taken = 1'b0;
        step();
        pred_valid = 1'b0; res_valid = 1'b1; res_taken = 1'b1; res_target = 32'h80;
        step();
        idle();
        chk("s5_flush_pre", 32'(flush), 32'd1);
        arst_n = 1'b0;
        #1;
        chk("s5_flush_rst", 32'(flush), 32'd0);
        chk("s5_redirect_rst", redirect_pc, 32'd0);
        arst_n = 1'b1;
        step();
        chk("s5_ready", 32'(pred_ready), 32'd1);
        chk("s5_count", 32'(dut.count_q), 32'd0);

        // Randomized traffic, mostly-correct resolves so the queue fills
        for (int n = 0; n < 3000; n++) begin
            pred_valid   = ($urandom_range(0, 1) == 1);
            pred_idx     = 5'($urandom);
            pred_taken   = 1'($urandom);
            res_valid    = ($urandom_range(0, 2) == 0);
            if (mq.size() > 0 && $urandom_range(0, 7) != 0) res_taken = mq[0].tkn;
            else res_taken = 1'($urandom);
            res_target   = $urandom;
            res_fallthru = $urandom;
            if (n % 700 == 350) pulse_reset();
            step();
        end
        idle();

`ifdef BRU_STATS_EN
        pulse_reset();
        pred_valid = 1'b1; pred_idx = 5'd1; pred_taken = 1'b1;
        step();
        res_valid = 1'b1; res_taken = 1'b1;
        for (int n = 0; n < 32'h10001; n++) step();
        idle();
        step();
        chk("stat_branches", 32'(stat_branches), 32'hFFFF);
        chk("stat_mispred", 32'(stat_mispred), 32'd0);
`endif

        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
